// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the adder/subtractor receive path.
//   DATAWIDTH_DEFAULT : default result word width
//   result_entry_t    : one stored result, laid out as {ovf, data}
//   entry_width()     : width of a stored entry for a given data width
//   count_width()     : width of a counter able to hold 0..depth inclusive
// -----------------------------------------------------------------------------
package addsub_pkg;

   localparam int DATAWIDTH_DEFAULT = 8;

   // Overflow flag travels in the MSB, directly above the result word
   typedef struct packed {
      logic                         ovf;
      logic [DATAWIDTH_DEFAULT-1:0] data;
   } result_entry_t;

   function automatic int entry_width(input int data_width);
      return data_width + 1;
   endfunction

   // Occupancy and credits both need to represent the value "depth" itself
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/addsub_result_fifo.sv
// -----------------------------------------------------------------------------
// addsub_result_fifo
// First-word-fall-through synchronous FIFO holding pipeline results.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, din       : write request and entry
//   pop             : consume the head entry (ignored when empty)
//   dout            : head entry, zero when empty
//   full, empty     : occupancy decodes
//   count           : current occupancy
// A push while full is only taken when a pop frees a slot in the same cycle.
// There is no bypass: an entry written into an empty FIFO appears next cycle.
// -----------------------------------------------------------------------------
module addsub_result_fifo
   import addsub_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [WIDTH-1:0]              din,
   input  logic                          pop,
   output logic [WIDTH-1:0]              dout,
   output logic                          full,
   output logic                          empty,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; occupancy is
   // tracked separately so full and empty never need pointer comparison
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is left unreset so it can map onto plain memory; stale words are
   // never visible because dout is masked while empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/addsub_result_collector.sv
// -----------------------------------------------------------------------------
// addsub_result_collector
// Captures the non-stallable result stream of the pipelined adder/subtractor
// into a FIFO and hands it downstream with valid/ready. A credit counter,
// preloaded with the FIFO depth, limits ops in flight so results can never
// overrun the FIFO.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   issue                   : op launched into the pipeline this cycle
//   credit_avail            : at least one credit left; source may issue
//   res_valid/res_data/res_ovf : pipeline output
//   m_valid/m_data/m_ovf    : FIFO head presented downstream
//   m_ready                 : consumer accepts the head
//   count                   : FIFO occupancy
//   issue_err               : sticky, issue seen with no credits
//   drop_err                : sticky, result dropped because FIFO full
// -----------------------------------------------------------------------------
module addsub_result_collector
   import addsub_pkg::*;
#(
   parameter int DATAWIDTH           = DATAWIDTH_DEFAULT,
   parameter int NUM_PIPELINE_STAGES = 4,
   parameter int FIFO_DEPTH          = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               issue,
   output logic                               credit_avail,
   input  logic                               res_valid,
   input  logic [DATAWIDTH-1:0]               res_data,
   input  logic                               res_ovf,
   output logic                               m_valid,
   output logic [DATAWIDTH-1:0]               m_data,
   output logic                               m_ovf,
   input  logic                               m_ready,
   output logic [count_width(FIFO_DEPTH)-1:0] count,
   output logic                               issue_err,
   output logic                               drop_err
);

   localparam int CW = count_width(FIFO_DEPTH);
   localparam int EW = entry_width(DATAWIDTH);

   // Elaboration-time sanity on the configuration
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end
   if (FIFO_DEPTH < NUM_PIPELINE_STAGES) begin : g_shallow_fifo
      $warning("FIFO_DEPTH below pipeline latency limits issue throughput");
   end

   logic [CW-1:0] credits;
   logic [EW-1:0] head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          issue_ok;
   logic          pop_fire;

   addsub_result_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (res_valid),
      .din   ({res_ovf, res_data}),
      .pop   (m_ready),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign m_valid      = !fifo_empty;
   assign m_ovf        = head[EW-1];
   assign m_data       = head[DATAWIDTH-1:0];
   assign credit_avail = (credits != '0);
   assign issue_ok     = issue && credit_avail;
   assign pop_fire     = m_valid && m_ready;

   // One credit per free FIFO slot: taken when an op is launched, returned
   // when its result leaves. Saturating at the depth keeps a pop of an entry
   // that never consumed a credit from inflating the pool.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= CW'(FIFO_DEPTH);
      end else if (issue_ok && !pop_fire) begin
         credits <= credits - CW'(1);
      end else if (!issue_ok && pop_fire && credits != CW'(FIFO_DEPTH)) begin
         credits <= credits + CW'(1);
      end
   end

   // Protocol violations are latched so software can detect them later;
   // only reset clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_err <= 1'b0;
         drop_err  <= 1'b0;
      end else begin
         if (issue && !credit_avail)              issue_err <= 1'b1;
         if (res_valid && fifo_full && !pop_fire) drop_err  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_addsub_result_collector.sv
// -----------------------------------------------------------------------------
// tb_addsub_result_collector
// Self-checking bench: a 4-stage adder/subtractor model feeds the collector,
// expected results are queued on issue and compared against the FIFO head.
// -----------------------------------------------------------------------------
module tb_addsub_result_collector;
   import addsub_pkg::*;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       issue     = 1'b0;
   logic       m_ready   = 1'b0;
   logic       injValid  = 1'b0;
   logic [7:0] injData   = 8'h00;
   logic       injOvf    = 1'b0;

   logic       credit_avail;
   logic       res_valid;
   logic [7:0] res_data;
   logic       res_ovf;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ovf;
   logic [3:0] count;
   logic       issue_err;
   logic       drop_err;

   logic [3:0]    pipeVld;
   result_entry_t pipeRes [4];
   result_entry_t issueRes = '0;

   result_entry_t sbQueue [$];
   logic [8:0]    popLog [$];
   int            checks   = 0;
   int            errors   = 0;
   int            popCount = 0;
   bit            wrapDone = 1'b0;

   addsub_result_collector #(
      .DATAWIDTH           (8),
      .NUM_PIPELINE_STAGES (4),
      .FIFO_DEPTH          (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue        (issue),
      .credit_avail (credit_avail),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .res_ovf      (res_ovf),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ovf        (m_ovf),
      .m_ready      (m_ready),
      .count        (count),
      .issue_err    (issue_err),
      .drop_err     (drop_err)
   );

   always #5 clk = ~clk;

   // Upstream pipeline output, with a side door for hand-injected results
   assign res_valid = pipeVld[3] | injValid;
   assign res_data  = injValid ? injData : pipeRes[3].data;
   assign res_ovf   = injValid ? injOvf  : pipeRes[3].ovf;

   // Four-stage pipeline model sharing the collector's reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipeVld <= '0;
         for (int i = 0; i < 4; i++) pipeRes[i] <= '0;
      end else begin
         pipeVld    <= {pipeVld[2:0], issue};
         pipeRes[0] <= issueRes;
         for (int i = 1; i < 4; i++) pipeRes[i] <= pipeRes[i-1];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Signed two's-complement add/subtract reference
   function automatic result_entry_t calcResult(input logic [7:0] a, input logic [7:0] b,
                                                input logic op);
      result_entry_t e;
      if (!op) begin
         e.data = a + b;
         e.ovf  = (a[7] == b[7]) && (e.data[7] != a[7]);
      end else begin
         e.data = a - b;
         e.ovf  = (a[7] != b[7]) && (e.data[7] != a[7]);
      end
      return e;
   endfunction

   // Head must always match the oldest outstanding expectation; a pop retires it
   always @(negedge clk) begin
      if (rst_n && m_valid) begin
         if (sbQueue.size() == 0) begin
            checkOutput("sb_unexpected", 32'd1, 32'd0);
         end else begin
            checkOutput("m_data", m_data, sbQueue[0].data);
            checkOutput("m_ovf", m_ovf, sbQueue[0].ovf);
            if (m_ready) begin
               void'(sbQueue.pop_front());
               popLog.push_back({m_ovf, m_data});
               popCount++;
            end
         end
      end
   end

   // Launch one op; called just after a rising edge, returns just after the next
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic op, input bit keep);
      issueRes = calcResult(a, b, op);
      issue    = 1'b1;
      if (keep) sbQueue.push_back(issueRes);
      @(posedge clk);
      #1;
      issue = 1'b0;
   endtask

   task automatic doReset();
      issue    = 1'b0;
      injValid = 1'b0;
      m_ready  = 1'b0;
      rst_n    = 1'b0;
      sbQueue.delete();
      popLog.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic waitCount(input int target, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (count == 4'(target)) break;
      end
      checkOutput(tag, count, target);
   endtask

   task automatic waitDrain(input int budget, input string tag);
      m_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sbQueue.size() == 0 && !m_valid && pipeVld == 4'b0 && !res_valid) break;
      end
      checkOutput({tag, "_sb_left"}, sbQueue.size(), 0);
      checkOutput({tag, "_count"}, count, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int resIdx;
      int mvIdx;
      int mvHigh;
      int sent;
      int popBase;

      // Reset state
      #12;
      checkOutput("rst_count", count, 0);
      checkOutput("rst_m_valid", m_valid, 0);
      checkOutput("rst_m_data", m_data, 0);
      checkOutput("rst_m_ovf", m_ovf, 0);
      checkOutput("rst_credit_avail", credit_avail, 1);
      checkOutput("rst_credits", dut.credits, 8);
      checkOutput("rst_issue_err", issue_err, 0);
      checkOutput("rst_drop_err", drop_err, 0);
      doReset();

      // Basic add with latency and single-cycle m_valid
      $display("[TB] basic add");
      m_ready = 1'b1;
      applyStimulus(8'd5, 8'd3, 1'b0, 1'b1);
      resIdx = -1; mvIdx = -1; mvHigh = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (res_valid && resIdx < 0) resIdx = k;
         if (m_valid) begin
            if (mvIdx < 0) mvIdx = k;
            mvHigh++;
         end
      end
      checkOutput("basic_latency", mvIdx - resIdx, 1);
      checkOutput("basic_mvalid_cycles", mvHigh, 1);
      checkOutput("basic_result", popLog[0], {1'b0, 8'h08});
      @(posedge clk);
      #1;
      checkOutput("basic_credits", dut.credits, 8);

      // Overflow then subtract, in order
      $display("[TB] overflow");
      popLog.delete();
      applyStimulus(8'd127, 8'd1, 1'b0, 1'b1);
      applyStimulus(8'd0, 8'd1, 1'b1, 1'b1);
      waitDrain(40, "ovf");
      checkOutput("ovf_pops", popLog.size(), 2);
      checkOutput("ovf_first", popLog[0], {1'b1, 8'h80});
      checkOutput("ovf_second", popLog[1], {1'b0, 8'hFF});

      // Credit exhaustion, then an illegal ninth issue whose result is dropped
      $display("[TB] credit exhaustion");
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) applyStimulus(8'(i * 3), 8'(i), 1'b0, 1'b1);
      checkOutput("exh_credit_avail", credit_avail, 0);
      checkOutput("exh_issue_err_clean", issue_err, 0);
      applyStimulus(8'd1, 8'd1, 1'b0, 1'b0);
      checkOutput("exh_issue_err", issue_err, 1);
      checkOutput("exh_credits_zero", dut.credits, 0);
      waitCount(8, 20, "exh_count_full");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("exh_drop_err", drop_err, 1);
      checkOutput("exh_count_kept", count, 8);
      waitDrain(60, "exh");
      checkOutput("exh_credits_back", dut.credits, 8);
      checkOutput("exh_issue_err_sticky", issue_err, 1);
      doReset();

      // Full FIFO: push with pop is legal, push without pop is dropped
      $display("[TB] full-and-pop");
      for (int i = 0; i < 8; i++) applyStimulus(8'(i + 100), 8'(i), 1'b1, 1'b1);
      waitCount(8, 20, "fap_count_full");
      @(posedge clk);
      #1;
      injValid = 1'b1; injData = 8'h5A; injOvf = 1'b0; m_ready = 1'b1;
      sbQueue.push_back('{ovf: 1'b0, data: 8'h5A});
      @(posedge clk);
      #1;
      injValid = 1'b0; m_ready = 1'b0;
      checkOutput("fap_count", count, 8);
      checkOutput("fap_drop_err_clean", drop_err, 0);
      checkOutput("fap_credits", dut.credits, 1);
      injValid = 1'b1; injData = 8'hA5; injOvf = 1'b1;
      @(posedge clk);
      #1;
      injValid = 1'b0;
      checkOutput("fap_drop_err", drop_err, 1);
      checkOutput("fap_count_after_drop", count, 8);
      waitDrain(60, "fap");
      checkOutput("fap_credits_saturate", dut.credits, 8);
      doReset();

      // Wrap-around: 20 results through with random backpressure
      $display("[TB] wrap-around");
      sent    = 0;
      popBase = popCount;
      fork
         begin
            for (int c = 0; c < 400 && sent < 20; c++) begin
               if (credit_avail) begin
                  applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                                1'($urandom_range(0, 1)), 1'b1);
                  sent++;
               end else begin
                  @(posedge clk);
                  #1;
               end
            end
            wrapDone = 1'b1;
         end
         begin
            while (!wrapDone) begin
               m_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      waitDrain(100, "wrap");
      checkOutput("wrap_sent", sent, 20);
      checkOutput("wrap_pops", popCount - popBase, 20);
      checkOutput("wrap_credits", dut.credits, 8);
      checkOutput("wrap_issue_err", issue_err, 0);
      checkOutput("wrap_drop_err", drop_err, 0);

      // Reset in the middle of traffic clears everything at once
      $display("[TB] reset mid-stream");
      m_ready = 1'b0;
      for (int i = 0; i < 7; i++) applyStimulus(8'(i + 1), 8'(2 * i), 1'b0, 1'b1);
      waitCount(5, 20, "mid_count_pre");
      checkOutput("mid_credits_pre", dut.credits, 1);
      #2;
      rst_n = 1'b0;
      sbQueue.delete();
      popLog.delete();
      #1;
      checkOutput("mid_count", count, 0);
      checkOutput("mid_m_valid", m_valid, 0);
      checkOutput("mid_credits", dut.credits, 8);
      checkOutput("mid_credit_avail", credit_avail, 1);
      checkOutput("mid_issue_err", issue_err, 0);
      checkOutput("mid_drop_err", drop_err, 0);
      #3;
      rst_n = 1'b1;
      m_ready = 1'b1;
      applyStimulus(8'd10, 8'd20, 1'b0, 1'b1);
      waitDrain(40, "post_rst");
      checkOutput("post_rst_result", popLog[0], {1'b0, 8'd30});
      checkOutput("post_rst_credits", dut.credits, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/addsub_result_collector.md
Name: addsub_result_collector

Overview:
Receive-side companion to the pipelined adder/subtractor. Captures the non-stallable Result/Overflow stream into a FIFO and presents it downstream with valid/ready. Issues credits to the operand source so that in-flight pipeline results can never overrun the FIFO. Sits between the adder/subtractor pipeline output and any consumer that may apply backpressure.

Parameters:
DATAWIDTH, 8, width of the result word
NUM_PIPELINE_STAGES, 4, latency of the upstream pipeline; informational only, with FIFO_DEPTH >= NUM_PIPELINE_STAGES required for full throughput
FIFO_DEPTH, 8, number of result entries; power of two, >= 2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
issue  in  1  operand source launches an op into the pipeline this cycle; same signal as the pipeline's i_valid
credit_avail  out  1  high when at least one credit remains; the source may assert issue only when this is high
res_valid  in  1  pipeline o_valid
res_data  in  DATAWIDTH  pipeline Result
res_ovf  in  1  pipeline Overflow
m_valid  out  1  FIFO head valid
m_data  out  DATAWIDTH  head result
m_ovf  out  1  head overflow flag
m_ready  in  1  consumer accepts the head entry
count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
issue_err  out  1  sticky flag: issue seen while credits == 0
drop_err  out  1  sticky flag: res_valid seen while FIFO full and not popping

Behaviour:
- Reset (asynchronous, rst_n low):
  - credits = FIFO_DEPTH, so credit_avail = 1.
  - count = 0, m_valid = 0, m_data = 0, m_ovf = 0.
  - issue_err = 0, drop_err = 0. Read and write pointers = 0.
- Credit counter, width $clog2(FIFO_DEPTH+1):
  - Decrement on an accepted issue (issue && credits != 0).
  - Increment on pop (m_valid && m_ready).
  - Both in the same cycle: unchanged.
  - Issue when credits == 0: the counter stays 0 and issue_err sets.
  - The counter never exceeds FIFO_DEPTH.
- credit_avail = (credits != 0). It is a registered-state decode with no combinational path from issue.
- Push:
  - Occurs on res_valid && (!full || pop).
  - Simultaneous push and pop at full is legal; count is unchanged.
  - res_valid while full and no pop: the entry is dropped, drop_err sets, and FIFO contents are unaffected.
  - Push and pop when empty: no bypass. The entry is written, and m_valid rises next cycle.
- Latency: res_valid at edge N gives m_valid = 1 after edge N+1. The FIFO is first-word-fall-through: m_data and m_ovf reflect the head and are stable while m_valid && !m_ready.
- Pop: on m_valid && m_ready the head advances. The next entry, if any, is visible the following cycle. m_ready while empty has no effect.
- Pointers: log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from count (count == FIFO_DEPTH / count == 0).
- Sticky errors clear only on reset.
- Reset mid-operation: all state clears immediately. The upstream pipeline shares rst_n, so no stale results follow. Any res_valid after reset is accepted normally.
- Ordering: results leave in arrival order. No reordering and no data modification.

Decomposition:
- Shared package addsub_pkg holds:
  - the DATAWIDTH default;
  - the result entry layout ({ovf, data}, width DATAWIDTH+1);
  - the credit/count width function.
- One sub-module, addsub_result_fifo: a parameterised FWFT synchronous FIFO (push, pop, full, empty, count). The collector wraps it with the credit counter and error flags.

Test Plan:
- Basic add: issue with A=5, B=3, op=0; pipeline returns res_data=8, res_ovf=0; m_ready=1 -> m_valid for one cycle at edge N+1 with m_data=8, m_ovf=0; credits return to 8.
- Overflow: A=127, B=1, op=0 -> m_data=128 (0x80), m_ovf=1. Then A=0, B=1, op=1 -> m_data=255, m_ovf=0, in order.
- Credit exhaustion: 8 back-to-back issues with m_ready=0 -> credit_avail falls after the 8th issue, count reaches 8, issue_err stays 0. A 9th issue -> issue_err=1, credits stay 0.
- Full-and-pop: FIFO full, res_valid and m_ready in the same cycle -> count stays 8, drop_err=0, new entry emerges last. The same scenario with m_ready=0 -> drop_err=1, contents unchanged.
- Wrap-around: 20 results through the 8-deep FIFO with random m_ready -> all 20 emerge in order; credits end at 8.
- Reset mid-stream: assert rst_n low with count=5 and credits=1 -> immediately count=0, m_valid=0, credits=8, issue_err=0, drop_err=0.
